// File: rtl/shift_mix.sv
// shift_mix: AES ShiftRows followed by MixColumns on NO_BLOCKS independent
// 128-bit states. It is a two-stage valid/ready pipeline.
//   stage 1 registers the ShiftRows result together with last and valid.
//   stage 2 registers the MixColumns result, or the ShiftRows result
//   unchanged when the beat is flagged as the final round.
// Each stage advances when it is empty or when the stage after it drains.
// A full pipeline can therefore accept a beat and release a beat in the
// same cycle without losing either one.
module shift_mix #(
  parameter int DATA_WIDTH = 512,
  parameter int NO_BLOCKS  = DATA_WIDTH >> 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic                  last_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  last_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int BLK_W = 128;

  // GF(2^8) multiply by 2, reduced by x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  // The output byte in row r, column c comes from column (c + r) mod 4
  // of the same row.
  function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] t;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      end
    end
    return t;
  endfunction

  // One column. a0 is row 0 and sits in the low byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] u0, u1, u2, u3;
    a0 = col[7:0];
    a1 = col[15:8];
    a2 = col[23:16];
    a3 = col[31:24];
    // Multiplying by 3 is done as xtime(a) ^ a.
    u0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    u1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    u2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    u3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {u3, u2, u1, u0};
  endfunction

  function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] t);
    logic [BLK_W-1:0] u;
    u = '0;
    for (int c = 0; c < 4; c++) begin
      u[32*c +: 32] = mix_column(t[32*c +: 32]);
    end
    return u;
  endfunction

  logic                  v1;
  logic                  v2;
  logic                  en1;
  logic                  en2;
  logic                  s1_last;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [DATA_WIDTH-1:0] sr_data;
  logic [DATA_WIDTH-1:0] mc_data;
  logic [DATA_WIDTH-1:0] s2_next;

  // Bytes never move across a block boundary. Each block gets its own
  // copy of the round logic.
  for (genvar b = 0; b < NO_BLOCKS; b++) begin : g_blk
    assign sr_data[BLK_W*b +: BLK_W] = shift_rows(data_in[BLK_W*b +: BLK_W]);
    assign mc_data[BLK_W*b +: BLK_W] = mix_columns(s1_data[BLK_W*b +: BLK_W]);
  end

  // Handshake: each stage advances when it is empty or when the stage after it drains.
  always_comb begin
    en2      = ~v2 | ready_out;
    en1      = ~v1 | en2;
    ready_in = en1;
    s2_next  = s1_last ? s1_data : mc_data;
  end

  // Stage 1: capture the ShiftRows result of an accepted beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v1      <= 1'b0;
      s1_last <= 1'b0;
      s1_data <= '0;
    end else if (en1) begin
      v1      <= valid_in & ready_in;
      s1_last <= last_in;
      s1_data <= sr_data;
    end
  end

  // Stage 2: capture MixColumns, or bypass it for the final round. It holds while stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v2       <= 1'b0;
      last_out <= 1'b0;
      data_out <= '0;
    end else if (en2) begin
      v2       <= v1;
      last_out <= s1_last;
      data_out <= s2_next;
    end
  end

  assign valid_out = v2;

endmodule

// File: tb/tb_shift_mix.sv
// Self-checking bench for shift_mix.
// The stimulus process pushes each accepted beat's expected result into a
// queue. The monitor compares every presented output against the head of
// that queue and pops the head when the beat leaves.
module tb_shift_mix;

  localparam int DW = 512;
  localparam int NB = DW / 128;

  logic          clk;
  logic          reset;
  logic          valid_in;
  logic          ready_in;
  logic          last_in;
  logic [DW-1:0] data_in;
  logic          valid_out;
  logic          ready_out;
  logic          last_out;
  logic [DW-1:0] data_out;

  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  int            checks;
  int            errors;

  shift_mix #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .last_in   (last_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .last_out  (last_out),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Full carry-less polynomial product, then reduction modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input int m);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (((m >> i) & 1) != 0) p ^= (16'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p ^= (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Reference model: ShiftRows, then a matrix product with the MixColumns
  // circulant matrix over GF(2^8), applied to every block.
  function automatic logic [DW-1:0] ref_round(input logic [DW-1:0] d, input logic last);
    logic [DW-1:0] o;
    logic [7:0]    s[4][4];
    logic [7:0]    t[4][4];
    logic [7:0]    val;
    int            coef[4];
    coef[0] = 2; coef[1] = 3; coef[2] = 1; coef[3] = 1;
    o = '0;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = d[128*b + 8*(4*c+r) +: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = s[r][(c+r)%4];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (last) val = t[r][c];
          else begin
            val = '0;
            for (int k = 0; k < 4; k++) val ^= gmul(t[k][c], coef[(k-r+4)%4]);
          end
          o[128*b + 8*(4*c+r) +: 8] = val;
        end
    end
    return o;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // Monitor: every presented beat must match the head of the queue. The head is popped on release.
  always @(negedge clk) begin
    if (reset && valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {{(DW-1){1'b0}}, valid_out}, '0);
      end else begin
        check("data_out", data_out, exp_q[0]);
        check("last_out", {{(DW-1){1'b0}}, last_out}, {{(DW-1){1'b0}}, exp_last_q[0]});
        if (ready_out) begin
          void'(exp_q.pop_front());
          void'(exp_last_q.pop_front());
        end
      end
    end
  end

  // Drives one cycle of inputs just after the clock edge. At the falling
  // edge it decides whether the next edge accepts the beat, and if so
  // pushes that beat's expected result into the queue.
  task automatic cycle(input logic vin, input logic [DW-1:0] d, input logic l, input logic rdy,
                       input logic [DW-1:0] ed, input logic el, output logic acc);
    @(posedge clk);
    #1;
    valid_in  = vin;
    data_in   = d;
    last_in   = l;
    ready_out = rdy;
    @(negedge clk);
    acc = vin && ready_in;
    if (acc) begin
      exp_q.push_back(ed);
      exp_last_q.push_back(el);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1, '0, 1'b0, acc);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l, input logic [DW-1:0] ed, input logic el);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) cycle(1'b1, d, l, 1'b1, ed, el, acc);
    check("send_accepted", {{(DW-1){1'b0}}, acc}, {{(DW-1){1'b0}}, 1'b1});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
    check(name, DW'(exp_q.size()), '0);
    idle(4);
  endtask

  function automatic logic [DW-1:0] rep(input logic [127:0] x);
    return {NB{x}};
  endfunction

  logic [127:0] in28, out28, in_db, out_db, in_f2, out_f2, in_01, in_fips, out_fips;
  logic [DW-1:0] d;
  logic          l;
  logic          acc;
  int            accepted;

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    valid_in = 1'b0;
    last_in  = 1'b0;
    data_in  = '0;
    ready_out = 1'b1;

    in28     = 128'h0f0e0d0c0b0a09080706050403020100;
    out28    = 128'h0b06010c07020d08030e09040f0a0500;
    in_db    = 128'h455313db455313db455313db455313db;
    out_db   = 128'hbca14d8ebca14d8ebca14d8ebca14d8e;
    in_f2    = 128'h5c220af25c220af25c220af25c220af2;
    out_f2   = 128'h9d58dc9f9d58dc9f9d58dc9f9d58dc9f;
    in_01    = 128'h01010101010101010101010101010101;
    in_fips  = 128'h3052411ee55db4b8f198bfe0ae1127d4;
    out_fips = 128'h4c2606287ad3f8489a19cbe0e5816604;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_out", {{(DW-1){1'b0}}, valid_out}, '0);
    check("rst_last_out", {{(DW-1){1'b0}}, last_out}, '0);
    check("rst_data_out", data_out, '0);
    reset = 1'b1;
    #1;
    check("rst_ready_in", {{(DW-1){1'b0}}, ready_in}, {{(DW-1){1'b0}}, 1'b1});

    // Final-round beat: ShiftRows only, and exactly two cycles of latency.
    cycle(1'b1, rep(in28), 1'b1, 1'b1, rep(out28), 1'b1, acc);
    check("lat_accept", {{(DW-1){1'b0}}, acc}, {{(DW-1){1'b0}}, 1'b1});
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    check("lat_cycle1", {{(DW-1){1'b0}}, valid_out}, '0);
    @(posedge clk);
    #1;
    check("lat_cycle2", {{(DW-1){1'b0}}, valid_out}, {{(DW-1){1'b0}}, 1'b1});
    idle(2);

    // Known MixColumns answers, then one beat with a different state in each block.
    send(rep(in_db), 1'b0, rep(out_db), 1'b0);
    send(rep(in_f2), 1'b0, rep(out_f2), 1'b0);
    send(rep(in_01), 1'b0, rep(in_01), 1'b0);
    send(rep(in_fips), 1'b0, rep(out_fips), 1'b0);
    send({in_fips, in_db, in_f2, in_01}, 1'b0, {out_fips, out_db, out_f2, in_01}, 1'b0);
    idle(1);
    drain("drain_directed");

    // Ten back-to-back beats. Downstream stalls in cycles 3 to 6.
    accepted = 0;
    for (int cyc = 0; accepted < 10 && cyc < 200; cyc++) begin
      d = rand_data();
      l = 1'($urandom_range(0, 1));
      cycle(1'b1, d, l, !(cyc >= 3 && cyc <= 6), ref_round(d, l), l, acc);
      if (cyc >= 3 && cyc <= 6)
        check("stall_ready_in", {{(DW-1){1'b0}}, acc}, '0);
      if (acc) accepted++;
    end
    check("stream_count", DW'(accepted), DW'(10));
    idle(1);
    drain("drain_stream");

    // Random valid, ready, last and data.
    accepted = 0;
    for (int cyc = 0; accepted < 300 && cyc < 5000; cyc++) begin
      d = rand_data();
      l = 1'($urandom_range(0, 3) == 0);
      cycle(1'($urandom_range(0, 3) != 0), d, l, 1'($urandom_range(0, 3) != 0),
            ref_round(d, l), l, acc);
      if (acc) accepted++;
    end
    check("random_count", DW'(accepted), DW'(300));
    idle(1);
    drain("drain_random");

    // Reset with two beats in flight. Neither beat may ever emerge.
    cycle(1'b1, rep(in_db), 1'b0, 1'b1, rep(out_db), 1'b0, acc);
    cycle(1'b1, rep(in_f2), 1'b0, 1'b1, rep(out_f2), 1'b0, acc);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    exp_q.delete();
    exp_last_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst2_valid_out", {{(DW-1){1'b0}}, valid_out}, '0);
    check("rst2_ready_in", {{(DW-1){1'b0}}, ready_in}, {{(DW-1){1'b0}}, 1'b1});
    check("rst2_data_out", data_out, '0);
    idle(8);

    // The pipeline must work normally after the reset.
    send(rep(in_fips), 1'b0, rep(out_fips), 1'b0);
    idle(1);
    drain("drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_mix.md
SHIFT_MIX -- requirements
Module: shift_mix

Interface
REQ-001 Parameter DATA_WIDTH, default 512, total state width in bits; SHALL be a multiple of 128.
REQ-002 Parameter NO_BLOCKS, default DATA_WIDTH >> 7, number of independent 128-bit AES states processed in parallel.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 valid_in  input  1  data_in and last_in are valid this cycle.
REQ-006 ready_in  output  1  block accepts data_in this cycle.
REQ-007 last_in  input  1  final-round flag; when 1, MixColumns is bypassed for this beat.
REQ-008 data_in  input  DATA_WIDTH  SubBytes output, NO_BLOCKS states.
REQ-009 valid_out  output  1  data_out and last_out are valid.
REQ-010 ready_out  input  1  downstream accepts data_out this cycle.
REQ-011 last_out  output  1  last_in carried with the beat.
REQ-012 data_out  output  DATA_WIDTH  ShiftRows(+MixColumns) result.

Function
REQ-013 Block b occupies bits [128b+127:128b]; byte i of a block occupies bits [8i+7:8i]; state element s[r][c] is byte 4c+r.
REQ-014 Stage 1 (ShiftRows) SHALL register t[r][c] = s[r][(c+r) mod 4] per block, with last and valid.
REQ-015 Stage 2 (MixColumns) SHALL register, per column, u0=2a0^3a1^a2^a3, u1=a0^2a1^3a2^a3, u2=a0^a1^2a2^3a3, u3=3a0^a1^a2^2a3, GF(2^8) multiply by 2 = xtime with reduction 0x1B.
REQ-016 When the stage-1 last flag is 1, stage 2 SHALL register t unchanged.
REQ-017 Latency SHALL be exactly 2 cycles from an accepted beat to valid_out with no backpressure; throughput 1 beat/cycle.
REQ-018 Stage enables: en2 = ~v2 | ready_out; en1 = ~v1 | en2; ready_in = en1 (combinational).
REQ-019 A beat is accepted when valid_in & ready_in; a beat leaves when valid_out & ready_out.
REQ-020 When en2=1, v2 <= v1 and stage-2 data/last load; when en1=1, v1 <= valid_in & ready_in and stage-1 data/last load.
REQ-021 While valid_out=1 and ready_out=0, data_out, last_out and valid_out SHALL hold stable.
REQ-022 Beats SHALL never be dropped, duplicated or reordered; simultaneous accept and release in a full pipeline SHALL be lossless.
REQ-023 valid_in while ready_in=0 SHALL be ignored; upstream holds the beat.
REQ-024 Blocks SHALL be processed independently; no bytes cross a 128-bit boundary.

Reset
REQ-025 While reset=0 at a clock edge: v1, v2, valid_out, last_out <= 0; data_out and stage-1 data <= 0.
REQ-026 Reset mid-operation SHALL discard all in-flight beats; ready_in SHALL be 1 in the first cycle after reset is released.
REQ-027 Reset SHALL have no effect between clock edges.

Verification
REQ-028 Block 0 bytes 00..0F, last_in=1, ready_out=1 -> two cycles later block 0 of data_out = 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B, last_out=1.
REQ-029 Column bytes DB 13 53 45 already in ShiftRows order (all four columns equal, so ShiftRows is identity), last_in=0 -> each output column 8E 4D A1 BC; column F2 0A 22 5C -> 9F DC 58 9D; 01 01 01 01 -> 01 01 01 01.
REQ-030 FIPS-197 Appendix B round 1 after SubBytes (D4 27 11 AE E0 BF 98 F1 B8 B4 5D E5 1E 41 52 30) -> 04 66 81 E5 E0 CB 19 9A 48 F8 D3 7A 28 06 26 4C in every block.
REQ-031 Stream 10 beats back-to-back, ready_out=0 for cycles 3-6 -> ready_in=0 once both stages are full, data_out held stable, all 10 beats out in order with no loss.
REQ-032 Assert reset for one cycle with two beats in flight -> valid_out=0 next cycle, no stale beat ever emerges, ready_in=1.
